// File: rtl/jedro_1_mem_arbiter.sv
// Two-master arbiter sharing one byte-writable, 1-cycle-latency RAM between the
// jedro_1 instruction-fetch port and the load/store port.
module jedro_1_mem_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int MAX_STARVE     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      ifu_req_i,
  input  logic [ADDR_WIDTH-1:0]     ifu_addr_i,
  output logic                      ifu_gnt_o,
  output logic                      ifu_rvalid_o,
  output logic [DATA_WIDTH-1:0]     ifu_rdata_o,

  input  logic                      lsu_req_i,
  input  logic                      lsu_we_i,
  input  logic [DATA_WIDTH/8-1:0]   lsu_be_i,
  input  logic [ADDR_WIDTH-1:0]     lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]     lsu_wdata_i,
  output logic                      lsu_gnt_o,
  output logic                      lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]     lsu_rdata_o,

  output logic                      ram_en_o,
  output logic [DATA_WIDTH/8-1:0]   ram_we_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0]     ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

  localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

  typedef enum logic [1:0] {
    IDLE,
    IFU_RD,
    LSU_RD,
    LSU_WR
  } owner_e;

  owner_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       ifu_win, lsu_win;

  // Word address only; the byte offset and bits above the RAM range are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ifu_addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2], ifu_addr_i[1:0],
                              lsu_addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2], lsu_addr_i[1:0]};

  // NOTE: every always_comb output gets a default before any branch, so no path
  // can leave a value unassigned and infer a latch.
  always_comb begin
    ifu_win = 1'b0;
    lsu_win = 1'b0;
    if (!rst_i) begin
      if (lsu_req_i && ifu_req_i) begin
        if (starve_q == STARVE_LIMIT) ifu_win = 1'b1;
        else                          lsu_win = 1'b1;
      end else if (lsu_req_i) begin
        lsu_win = 1'b1;
      end else if (ifu_req_i) begin
        ifu_win = 1'b1;
      end
    end
  end

  assign ifu_gnt_o = ifu_win;
  assign lsu_gnt_o = lsu_win;

  always_comb begin
    ram_en_o    = ifu_win | lsu_win;
    ram_we_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (lsu_win) begin
      ram_addr_o  = lsu_addr_i[RAM_ADDR_WIDTH+1:2];
      ram_wdata_o = lsu_wdata_i;
      if (lsu_we_i) ram_we_o = lsu_be_i;
    end else if (ifu_win) begin
      ram_addr_o = ifu_addr_i[RAM_ADDR_WIDTH+1:2];
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!ifu_req_i || ifu_win)       starve_d = '0;
    else if (starve_q != STARVE_LIMIT) starve_d = starve_q + 4'd1;
  end

  // The owner of the next RAM read beat is whoever wins this cycle.
  always_comb begin
    state_d = IDLE;
    if (ifu_win)      state_d = IFU_RD;
    else if (lsu_win) state_d = lsu_we_i ? LSU_WR : LSU_RD;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Responses are masked during reset so a beat owed from before reset is dropped.
  always_comb begin
    ifu_rvalid_o = 1'b0;
    ifu_rdata_o  = '0;
    lsu_rvalid_o = 1'b0;
    lsu_rdata_o  = '0;
    if (!rst_i) begin
      unique case (state_q)
        IFU_RD: begin
          ifu_rvalid_o = 1'b1;
          ifu_rdata_o  = ram_rdata_i;
        end
        LSU_RD: begin
          lsu_rvalid_o = 1'b1;
          lsu_rdata_o  = ram_rdata_i;
        end
        LSU_WR:  lsu_rvalid_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Directed bench for jedro_1_mem_arbiter with a behavioural byte-writable RAM
// of 1-cycle read latency.
module tb_jedro_1_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ifu_req_i;
  logic [31:0] ifu_addr_i;
  logic        ifu_gnt_o, ifu_rvalid_o;
  logic [31:0] ifu_rdata_o;
  logic        lsu_req_i, lsu_we_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_gnt_o, lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [9:0]  ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] W0 = 32'h1111_0000;
  localparam logic [31:0] W1 = 32'h2222_0004;
  localparam logic [31:0] W2 = 32'h0010_0093;
  localparam logic [31:0] W4 = 32'h0123_4567;

  jedro_1_mem_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(10), .MAX_STARVE(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(ifu_gnt_o),
    .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // RAM model; preload happens while reset is held so the array has one writer.
  logic [31:0] mem [0:1023];
  always @(posedge clk_i) begin
    if (rst_i) begin
      mem[0] <= W0;
      mem[1] <= W1;
      mem[2] <= W2;
      mem[4] <= W4;
    end else if (ram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      ram_rdata_i <= mem[ram_addr_o];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle's drive point, just after the rising edge.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ifu_gnt"},  ifu_gnt_o,    0);
    check({tag, "_lsu_gnt"},  lsu_gnt_o,    0);
    check({tag, "_ram_en"},   ram_en_o,     0);
    check({tag, "_ram_we"},   ram_we_o,     0);
    check({tag, "_ram_addr"}, ram_addr_o,   0);
    check({tag, "_ram_wd"},   ram_wdata_o,  0);
    check({tag, "_ifu_rv"},   ifu_rvalid_o, 0);
    check({tag, "_ifu_rd"},   ifu_rdata_o,  0);
    check({tag, "_lsu_rv"},   lsu_rvalid_o, 0);
    check({tag, "_lsu_rd"},   lsu_rdata_o,  0);
  endtask

  initial begin
    logic [9:0] ifu_turn;
    logic       prev_ifu;
    ifu_turn = 10'b10_0001_0000;

    rst_i = 1'b1;
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_be_i = 4'hF;
    lsu_addr_i = 32'h4; lsu_wdata_i = 32'hDEAD_BEEF;
    #1;

    // Reset held three cycles with both masters requesting.
    for (int i = 0; i < 3; i++) begin
      sample();
      check_quiet("reset");
      next_cycle();
    end
    rst_i = 1'b0;

    // First cycle after release: LSU wins, no response yet.
    sample();
    check("rel_lsu_gnt", lsu_gnt_o, 1);
    check("rel_ifu_gnt", ifu_gnt_o, 0);
    check("rel_ram_addr", ram_addr_o, 1);
    check("rel_ram_wd", ram_wdata_o, 32'hDEAD_BEEF);
    check("rel_lsu_rv", lsu_rvalid_o, 0);
    check("rel_ifu_rv", ifu_rvalid_o, 0);

    // IFU-only fetch of 0x8 while the LSU read of word 1 returns.
    next_cycle();
    lsu_req_i = 1'b0;
    sample();
    check("fetch_ifu_gnt", ifu_gnt_o, 1);
    check("fetch_lsu_gnt", lsu_gnt_o, 0);
    check("fetch_ram_addr", ram_addr_o, 2);
    check("fetch_ram_wd", ram_wdata_o, 0);
    check("lsu_rd1_rv", lsu_rvalid_o, 1);
    check("lsu_rd1_data", lsu_rdata_o, W1);
    check("lsu_rd1_ifu_rv", ifu_rvalid_o, 0);

    // Byte write to 0x10 while the fetch returns.
    next_cycle();
    ifu_req_i = 1'b0;
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'b0100;
    lsu_addr_i = 32'h10; lsu_wdata_i = 32'hAABB_CCDD;
    sample();
    check("fetch_rv", ifu_rvalid_o, 1);
    check("fetch_data", ifu_rdata_o, W2);
    check("fetch_lsu_rv", lsu_rvalid_o, 0);
    check("wr_gnt", lsu_gnt_o, 1);
    check("wr_ram_we", ram_we_o, 4'b0100);
    check("wr_ram_addr", ram_addr_o, 4);
    check("wr_ram_wd", ram_wdata_o, 32'hAABB_CCDD);

    // Read back 0x10 while the write response returns.
    next_cycle();
    lsu_we_i = 1'b0; lsu_be_i = 4'hF; lsu_wdata_i = 32'h0;
    sample();
    check("wr_resp_rv", lsu_rvalid_o, 1);
    check("wr_resp_data", lsu_rdata_o, 0);
    check("rd_ram_we", ram_we_o, 0);
    check("rd_gnt", lsu_gnt_o, 1);

    next_cycle();
    lsu_req_i = 1'b0;
    sample();
    check("rd_resp_rv", lsu_rvalid_o, 1);
    check("rd_resp_byte2", lsu_rdata_o[23:16], 8'hBB);
    check("rd_resp_word", lsu_rdata_o, 32'h01BB_4567);
    check("idle_ram_en", ram_en_o, 0);

    next_cycle();
    sample();
    check("idle_lsu_rv", lsu_rvalid_o, 0);
    check("idle_ifu_rv", ifu_rvalid_o, 0);
    check("idle_lsu_rd", lsu_rdata_o, 0);

    // Contention: LSU wins four cycles, then IFU is forced through.
    next_cycle();
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h0;
    prev_ifu = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sample();
      check($sformatf("cont%0d_ifu_gnt", k), ifu_gnt_o, ifu_turn[k]);
      check($sformatf("cont%0d_lsu_gnt", k), lsu_gnt_o, !ifu_turn[k]);
      if (k > 0) begin
        check($sformatf("cont%0d_ifu_rv", k), ifu_rvalid_o, prev_ifu);
        check($sformatf("cont%0d_lsu_rv", k), lsu_rvalid_o, !prev_ifu);
        check($sformatf("cont%0d_ifu_rd", k), ifu_rdata_o, prev_ifu ? W2 : 32'h0);
        check($sformatf("cont%0d_lsu_rd", k), lsu_rdata_o, prev_ifu ? 32'h0 : W0);
      end
      prev_ifu = ifu_turn[k];
      next_cycle();
    end
    ifu_req_i = 1'b0; lsu_req_i = 1'b0;
    sample();
    check("cont_tail_ifu_rv", ifu_rvalid_o, 1);
    check("cont_tail_ifu_rd", ifu_rdata_o, W2);
    check("cont_tail_lsu_rv", lsu_rvalid_o, 0);

    // Interleaved single-master traffic: IFU 0x0 on even cycles, LSU 0x4 on odd.
    next_cycle();
    ifu_addr_i = 32'h0; lsu_addr_i = 32'h4;
    for (int j = 0; j < 8; j++) begin
      ifu_req_i = (j % 2 == 0);
      lsu_req_i = (j % 2 == 1);
      sample();
      check($sformatf("il%0d_ifu_gnt", j), ifu_gnt_o, (j % 2 == 0));
      check($sformatf("il%0d_lsu_gnt", j), lsu_gnt_o, (j % 2 == 1));
      if (j > 0) begin
        check($sformatf("il%0d_ifu_rv", j), ifu_rvalid_o, (j % 2 == 1));
        check($sformatf("il%0d_lsu_rv", j), lsu_rvalid_o, (j % 2 == 0));
        check($sformatf("il%0d_ifu_rd", j), ifu_rdata_o, (j % 2 == 1) ? W0 : 32'h0);
        check($sformatf("il%0d_lsu_rd", j), lsu_rdata_o, (j % 2 == 0) ? W1 : 32'h0);
      end
      next_cycle();
    end
    ifu_req_i = 1'b0; lsu_req_i = 1'b0;
    sample();
    check("il_tail_lsu_rv", lsu_rvalid_o, 1);
    check("il_tail_lsu_rd", lsu_rdata_o, W1);
    check("il_tail_ifu_rv", ifu_rvalid_o, 0);

    // LSU read granted, then reset the next cycle: the response must vanish.
    next_cycle();
    lsu_req_i = 1'b1; lsu_addr_i = 32'h4;
    sample();
    check("rst_mid_gnt", lsu_gnt_o, 1);
    next_cycle();
    rst_i = 1'b1;
    sample();
    check_quiet("rst_mid");
    next_cycle();
    rst_i = 1'b0;
    lsu_req_i = 1'b0;
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8;
    sample();
    check("post_rst_ifu_gnt", ifu_gnt_o, 1);
    check("post_rst_lsu_rv", lsu_rvalid_o, 0);
    check("post_rst_ifu_rv", ifu_rvalid_o, 0);
    next_cycle();
    ifu_req_i = 1'b0;
    sample();
    check("post_rst_fetch_rv", ifu_rvalid_o, 1);
    check("post_rst_fetch_rd", ifu_rdata_o, W2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jedro_1_mem_arbiter.md
Name: jedro_1_mem_arbiter

Overview:
Shares one single-port, byte-writable RAM (1-cycle read latency) between the jedro_1 instruction-fetch port (IFU, read-only) and the load/store port (LSU, read/write). LSU requests have fixed priority over IFU requests. A starvation counter guarantees IFU forward progress. A response-owner FSM routes each read-data beat back to the requester that issued it. The block sits between jedro_1_top's memory masters and a unified instruction/data RAM.

Parameters:
DATA_WIDTH, 32, data bus width in bits; byte enables are DATA_WIDTH/8 bits.
ADDR_WIDTH, 32, requester byte-address width.
RAM_ADDR_WIDTH, 10, RAM word-address width.
MAX_STARVE, 4, number of consecutive cycles IFU may be denied while requesting before it is force-granted; legal range 1..15.

Ports:
clk_i  in  1  clock; everything samples on the rising edge.
rst_i  in  1  synchronous reset, active-high.
ifu_req_i  in  1  IFU read request.
ifu_addr_i  in  ADDR_WIDTH  IFU byte address.
ifu_gnt_o  out  1  IFU request accepted this cycle.
ifu_rvalid_o  out  1  IFU read data valid.
ifu_rdata_o  out  DATA_WIDTH  IFU read data.
lsu_req_i  in  1  LSU request.
lsu_we_i  in  1  1 = write, 0 = read.
lsu_be_i  in  DATA_WIDTH/8  LSU byte enables (writes only).
lsu_addr_i  in  ADDR_WIDTH  LSU byte address.
lsu_wdata_i  in  DATA_WIDTH  LSU write data.
lsu_gnt_o  out  1  LSU request accepted this cycle.
lsu_rvalid_o  out  1  LSU response valid; issued for both reads and writes.
lsu_rdata_o  out  DATA_WIDTH  LSU read data.
ram_en_o  out  1  RAM access enable.
ram_we_o  out  DATA_WIDTH/8  RAM byte write enables.
ram_addr_o  out  RAM_ADDR_WIDTH  RAM word address.
ram_wdata_o  out  DATA_WIDTH  RAM write data.
ram_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after ram_en_o.

Behaviour:
- Grant is combinational, decided in the same cycle as the request. At most one of ifu_gnt_o or lsu_gnt_o is high in any cycle.
- Arbitration when both requesters are active:
  - Grant LSU, unless starve_cnt == MAX_STARVE.
  - If starve_cnt == MAX_STARVE, grant IFU.
- Arbitration when only one requester is active: grant it.
- Arbitration when neither is active: no grant; ram_en_o=0.
- starve_cnt (4-bit register):
  - Cleared when ifu_req_i=0 or ifu_gnt_o=1.
  - Otherwise incremented, saturating at MAX_STARVE.
- RAM drive:
  - ram_en_o = any grant.
  - ram_addr_o = granted addr[RAM_ADDR_WIDTH+1:2]; addr[1:0] is ignored and no misalignment error is raised.
  - ram_we_o = lsu_be_i when LSU is granted with lsu_we_i=1; otherwise 0.
  - ram_wdata_o = lsu_wdata_i when LSU is granted; otherwise 0.
- Response owner FSM (registered) with states IDLE, IFU_RD, LSU_RD, LSU_WR. Next state is set from the grant in the current cycle: IFU grant -> IFU_RD; LSU read -> LSU_RD; LSU write -> LSU_WR; no grant -> IDLE.
- Responses (latency exactly 1 cycle after the grant):
  - IFU_RD: ifu_rvalid_o=1, ifu_rdata_o=ram_rdata_i.
  - LSU_RD: lsu_rvalid_o=1, lsu_rdata_o=ram_rdata_i.
  - LSU_WR: lsu_rvalid_o=1, lsu_rdata_o=0.
  - In every other case each rdata output is 0.
- Back-to-back: a new grant may occur in the same cycle a response is returned. Full throughput is 1 access per cycle.
- Reset:
  - While rst_i=1: FSM=IDLE, starve_cnt=0, all gnt/rvalid/ram_en_o/ram_we_o=0, all data outputs 0, regardless of requests.
  - A grant issued in the cycle before rst_i is asserted produces no rvalid.
  - No rvalid in the first cycle after reset deassertion.
- Requesters must hold req and its payload stable until gnt. The arbiter does not register requests.

Test Plan:
- Reset: rst_i=1 for 3 cycles with both req=1 -> all outputs 0. First cycle after release: lsu_gnt_o=1, no rvalid.
- IFU-only fetch: ifu_req_i=1, addr 0x0000_0008 -> ram_addr_o=2, ifu_gnt_o=1. Next cycle ifu_rvalid_o=1 and ifu_rdata_o equals RAM word 2 (preloaded 0x0010_0093).
- LSU byte write then read: write be=4'b0100, addr 0x10, wdata 0xAABBCCDD -> ram_we_o=4'b0100, lsu_rvalid_o=1 next cycle with lsu_rdata_o=0. Then read 0x10 -> lsu_rdata_o[23:16]=0xBB.
- Contention with starvation, MAX_STARVE=4: both req held continuously -> LSU granted on cycles 0-3, IFU on cycle 4, LSU on cycles 5-8, IFU on cycle 9. Responses are routed to the correct port each cycle.
- Interleaved back-to-back traffic: alternating IFU/LSU reads to 0x0 and 0x4 for 8 cycles -> exactly one gnt per cycle, rvalid every cycle, no data crossed between ports.
- Reset mid-operation: LSU read granted at cycle N, rst_i=1 at cycle N+1 -> lsu_rvalid_o stays 0. Following IFU request after release is served normally.
